// File: rtl/ecpu_pkg.sv
// Shared types and constants for the eCPU front end.
package ecpu_pkg;

  // Instruction width agreed between fetch and decode.
  localparam int unsigned ECPU_ILEN = 32;

  // Canonical RV32I NOP (addi x0, x0, 0).
  localparam logic [ECPU_ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    S_RUN,
    S_FLUSH
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with synchronous flush; head is visible combinationally.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW:0]      r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == (PW+1)'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign data_o    = r_mem[r_rd_ptr];
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_do_push = push_i && (!w_full || pop_i);
  assign w_do_pop  = pop_i && !empty_o;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointer and occupancy tracking; flush empties the buffer in one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    !(push_i && w_full && !pop_i));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    !(pop_i && empty_o));

endmodule

// File: rtl/fetch_unit.sv
// In-order instruction fetch: PC generation, credit-limited memory requests,
// response buffering and redirect handling with stale-response discard.
module fetch_unit
  import ecpu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           ILEN            = ECPU_ILEN,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter int unsigned           FIFO_DEPTH      = 2,
  parameter int unsigned           MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ready_i,
  input  logic                  imem_rvalid_i,
  input  logic [ILEN-1:0]       imem_rdata_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ILEN-1:0]       instr_o,
  output logic                  instr_valid_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1) + 1;
  localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DW = ADDR_WIDTH + ILEN;
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_resp_pc;
  logic [CW-1:0]         r_live_cnt;
  logic [CW-1:0]         r_discard_cnt;
  fetch_state_t          r_state;

  logic [ADDR_WIDTH-1:0] w_redirect_pc;
  logic [FW-1:0]         w_fifo_count;
  logic                  w_fifo_empty;
  logic [DW-1:0]         w_fifo_head;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_push;
  logic                  w_pop;
  logic [CW-1:0]         w_discard_next;

  assign w_redirect_pc = redirect_pc_i & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  // Credit rule: bound both in-flight requests and live requests plus buffered words.
  assign imem_req_o  = !rst_i
                     && ((r_live_cnt + r_discard_cnt) < MAX_C)
                     && ((r_live_cnt + CW'(w_fifo_count)) < DEPTH_C);
  assign imem_addr_o = r_fetch_pc;
  assign w_accept    = imem_req_o && imem_ready_i;

  assign w_drop = imem_rvalid_i && (r_discard_cnt != '0);
  assign w_push = imem_rvalid_i && !w_drop && !redirect_i;
  assign w_pop  = !w_fifo_empty && !stall_i && !redirect_i;

  assign instr_valid_o = !w_fifo_empty;
  assign pc_o          = w_fifo_empty ? '0 : w_fifo_head[DW-1:ILEN];
  assign instr_o       = w_fifo_empty ? '0 : w_fifo_head[ILEN-1:0];

  // On redirect every request still owed by memory becomes a discard, less the
  // one answered this cycle (whichever stream it belonged to).
  always_comb begin
    w_discard_next = r_discard_cnt - CW'(w_drop);
    if (redirect_i) begin
      w_discard_next = r_discard_cnt + r_live_cnt + CW'(w_accept) - CW'(imem_rvalid_i);
    end
  end

  fetch_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  ({r_resp_pc, imem_rdata_i}),
    .data_o  (w_fifo_head),
    .count_o (w_fifo_count),
    .empty_o (w_fifo_empty)
  );

  // PC counters, request bookkeeping and the run/flush state machine.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_live_cnt    <= '0;
      r_discard_cnt <= '0;
      r_state       <= S_RUN;
    end else if (redirect_i) begin
      r_fetch_pc    <= w_redirect_pc;
      r_resp_pc     <= w_redirect_pc;
      r_live_cnt    <= '0;
      r_discard_cnt <= w_discard_next;
      r_state       <= (w_discard_next != '0) ? S_FLUSH : S_RUN;
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
      if (w_push)   r_resp_pc  <= r_resp_pc + ADDR_WIDTH'(4);
      r_live_cnt    <= r_live_cnt + CW'(w_accept) - CW'(w_push);
      r_discard_cnt <= w_discard_next;
      case (r_state)
        S_RUN:   r_state <= S_RUN;
        S_FLUSH: r_state <= (w_discard_next == '0) ? S_RUN : S_FLUSH;
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers requests, the
// stimulus pushes expected {pc, instr} pairs, and a monitor pops and compares
// every instruction decode consumes.
module tb_fetch_unit;
  import ecpu_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        instr_valid_o;

  logic        stim_redir;
  logic        model_redir;
  logic        arm_fire;
  logic        fired;
  logic        const_data;
  logic        ready_toggle;
  int          lat;
  int          cyc;
  int          n_checks;
  int          n_fail;

  exp_t  exp_q[$];
  pend_t pend_q[$];

  assign redirect_i = stim_redir | model_redir;

  fetch_unit #(
    .ADDR_WIDTH      (32),
    .ILEN            (32),
    .RESET_PC        (32'h0000_0000),
    .FIFO_DEPTH      (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return const_data ? 32'h0000_0013 : (a ^ 32'h5A5A_0013);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: responses at negedge, acceptance observed 1 ns later.
  initial begin : mem_model
    logic        accept;
    logic        redir_now;
    logic        prev_hold;
    logic [31:0] prev_addr;
    logic [31:0] exp_fetch;
    imem_ready_i  = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    model_redir   = 1'b0;
    fired         = 1'b0;
    cyc           = 0;
    prev_hold     = 1'b0;
    prev_addr     = '0;
    exp_fetch     = '0;
    forever begin
      @(negedge clk);
      cyc++;
      model_redir   = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      if (rst_i) begin
        pend_q.delete();
      end else if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
      imem_ready_i = ready_toggle ? ((cyc % 2) == 1) : 1'b1;
      #1;
      accept = imem_req_o && imem_ready_i;
      if (arm_fire && !fired && accept && imem_rvalid_i) begin
        model_redir = 1'b1;
        fired       = 1'b1;
      end
      redir_now = stim_redir | model_redir;
      if (rst_i) begin
        exp_fetch = 32'h0000_0000;
        prev_hold = 1'b0;
      end else begin
        if (prev_hold && imem_req_o) check("addr_stable", imem_addr_o, prev_addr);
        if (accept) begin
          check("req_addr", imem_addr_o, exp_fetch);
          check("outstanding_le_2", 32'(pend_q.size() + (imem_rvalid_i ? 1 : 0) + 1 <= 2), 32'd1);
          pend_q.push_back('{addr: imem_addr_o, due: cyc + lat});
          exp_fetch = exp_fetch + 32'd4;
        end
        if (redir_now) exp_fetch = redirect_pc_i & 32'hFFFF_FFFC;
        prev_hold = imem_req_o && !imem_ready_i && !redir_now;
        prev_addr = imem_addr_o;
      end
    end
  end

  // Monitor: every consumed instruction must match the scoreboard head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #7;
      if (!rst_i && instr_valid_o && !stall_i && !redirect_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instr: got pc %h instr %h, expected none", pc_o, instr_o);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", pc_o, e.pc);
          check("sb_instr", instr_o, e.instr);
        end
      end
    end
  end

  task automatic redirect_to(input logic [31:0] tgt, input int n_exp, input logic stall_after);
    logic [31:0] base;
    base = tgt & 32'hFFFF_FFFC;
    @(posedge clk); #1;
    stim_redir    = 1'b1;
    redirect_pc_i = tgt;
    exp_q.delete();
    for (int i = 0; i < n_exp; i++) begin
      exp_q.push_back('{pc: base + 32'(4 * i), instr: word(base + 32'(4 * i))});
    end
    @(posedge clk); #1;
    stim_redir = 1'b0;
    stall_i    = stall_after;
    #7;
    check("valid_after_redirect", 32'(instr_valid_o), 32'd0);
    check("addr_after_redirect", imem_addr_o, base);
  endtask

  task automatic drain(input int budget, input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(posedge clk); #8;
      i++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d entries left, expected 0", name, exp_q.size());
    end
    @(posedge clk); #1;
    stall_i = 1'b1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int waited;
    n_checks      = 0;
    n_fail        = 0;
    rst_i         = 1'b1;
    stall_i       = 1'b0;
    stim_redir    = 1'b0;
    redirect_pc_i = '0;
    arm_fire      = 1'b0;
    const_data    = 1'b1;
    ready_toggle  = 1'b0;
    lat           = 1;

    // Reset state.
    repeat (3) @(posedge clk);
    #8;
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_req", 32'(imem_req_o), 32'd0);

    // Stream from reset, k = 1, NOP everywhere.
    for (int i = 0; i < 8; i++) exp_q.push_back('{pc: 32'(4 * i), instr: 32'h0000_0013});
    @(posedge clk); #1;
    rst_i = 1'b0;
    #7;
    check("first_req", 32'(imem_req_o), 32'd1);
    check("first_addr", imem_addr_o, 32'd0);
    check("valid_c0", 32'(instr_valid_o), 32'd0);
    @(posedge clk); #8;
    check("valid_c1", 32'(instr_valid_o), 32'd0);
    @(posedge clk); #8;
    check("valid_c2", 32'(instr_valid_o), 32'd1);
    check("first_pc", pc_o, 32'd0);
    drain(60, "reset_stream");

    // Stall with a full buffer.
    const_data = 1'b0;
    redirect_to(32'h0000_0100, 8, 1'b1);
    waited = 0;
    while (!instr_valid_o && waited < 20) begin
      @(posedge clk); #8;
      waited++;
    end
    check("stall_fill", 32'(instr_valid_o), 32'd1);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #8;
      check("stall_pc", pc_o, 32'h0000_0100);
      check("stall_instr", instr_o, 32'h0000_0100 ^ 32'h5A5A_0013);
      check("stall_req", 32'(imem_req_o), 32'd0);
    end
    @(posedge clk); #1;
    stall_i = 1'b0;
    drain(60, "stall");

    // Redirect with two requests outstanding, k = 3.
    repeat (6) @(posedge clk);
    lat = 3;
    redirect_to(32'h0000_0800, 0, 1'b1);
    waited = 0;
    while (pend_q.size() != 2 && waited < 20) begin
      @(posedge clk); #8;
      waited++;
    end
    check("two_outstanding", 32'(pend_q.size()), 32'd2);
    redirect_to(32'h0000_1002, 8, 1'b0);
    drain(100, "redirect_outstanding");

    // Redirect coincident with a response and an accepted request, k = 1.
    lat = 1;
    redirect_to(32'h0000_1800, 16, 1'b0);
    redirect_pc_i = 32'h0000_2000;
    arm_fire      = 1'b1;
    waited = 0;
    while (!fired && waited < 40) begin
      @(posedge clk); #8;
      waited++;
    end
    check("coincident_fired", 32'(fired), 32'd1);
    arm_fire = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{pc: 32'h0000_2000 + 32'(4 * i), instr: word(32'h0000_2000 + 32'(4 * i))});
    end
    @(posedge clk); #8;
    check("coincident_valid", 32'(instr_valid_o), 32'd0);
    check("coincident_fsm", 32'(dut.r_state), 32'(S_FLUSH));
    check("coincident_addr", imem_addr_o, 32'h0000_2000);
    drain(60, "coincident");

    // Slow memory, k = 3, ready toggling.
    lat          = 3;
    ready_toggle = 1'b1;
    redirect_to(32'h0000_3000, 8, 1'b0);
    drain(200, "slow_mem");
    ready_toggle = 1'b0;

    // Address wrap at the top of the space.
    lat = 1;
    redirect_to(32'hFFFF_FFF8, 4, 1'b0);
    drain(60, "wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
